inst_queue: RTL and testbench

Instruction queue between the instruction fetcher and the decoder. It buffers fetched instructions with their PCs so fetch can run ahead of decode. It exposes a `full` back-pressure signal to the fetcher and a valid/ready pop handshake to the decoder. A flush from the reorder buffer empties it in one cycle on mispredict or exception.

---
 rtl/inst_queue_pkg.sv | 13 +
 rtl/inst_queue.sv | 77 +++++++
 tb/tb_inst_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and entry layout for the instruction queue between fetch and decode.
package inst_queue_pkg;

  localparam int unsigned INST_WID = 32;
  localparam int unsigned ADDR_WID = 32;
  localparam int unsigned IQ_DEPTH = 16;

  typedef struct packed {
    logic [INST_WID-1:0] inst;
    logic [ADDR_WID-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue: buffers fetched {inst, pc} pairs for the decoder, with a
// single-cycle flush from the reorder buffer.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_push,
  input  logic [INST_WID-1:0] if_inst,
  input  logic [ADDR_WID-1:0] if_pc,
  output logic                iq_full,
  output logic                dec_valid,
  output logic [INST_WID-1:0] dec_inst,
  output logic [ADDR_WID-1:0] dec_pc,
  input  logic                dec_ready,
  input  logic                rob_clear
);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_acc, pop_acc, mem_we;

  // Full depends only on registered count, so a same-cycle pop never admits a push.
  assign iq_full   = (count_q == (PTR_W+1)'(DEPTH));
  assign dec_valid = (count_q != '0);
  assign dec_inst  = mem_q[head_q].inst;
  assign dec_pc    = mem_q[head_q].pc;

  assign push_acc = if_push && !iq_full;
  assign pop_acc  = dec_ready && dec_valid;
  assign mem_we   = rdy && !rob_clear && push_acc;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (rob_clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_acc) tail_d = tail_q + PTR_W'(1);
        if (pop_acc)  head_d = head_q + PTR_W'(1);
        unique case ({push_acc, pop_acc})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_q] <= '{inst: if_inst, pc: if_pc};
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, if_push, dec_ready, rob_clear;
  logic [31:0] if_inst, if_pc;
  logic        iq_full, dec_valid;
  logic [31:0] dec_inst, dec_pc;

  int n_vec = 0;
  int n_err = 0;
  int n_pop;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .if_push   (if_push),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .iq_full   (iq_full),
    .dec_valid (dec_valid),
    .dec_inst  (dec_inst),
    .dec_pc    (dec_pc),
    .dec_ready (dec_ready),
    .rob_clear (rob_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc);
    if_push = 1'b1;
    if_pc   = pc;
    if_inst = {16'h1300, pc[15:0]};
    step();
    if_push = 1'b0;
  endtask

  // Pop until empty, bounded so a stuck dec_valid cannot hang the run.
  task automatic drain(output int n);
    n = 0;
    dec_ready = 1'b1;
    while (dec_valid && n < 40) begin
      step();
      n++;
    end
    dec_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; if_push = 1'b0; dec_ready = 1'b0; rob_clear = 1'b0;
    if_inst = '0; if_pc = '0;

    // Reset / empty
    #12;
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_full", {31'b0, iq_full}, 32'd0);
    rst = 1'b1;
    step();
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("empty_pop_valid", {31'b0, dec_valid}, 32'd0);

    // Order and latency
    if_push = 1'b1; if_inst = 32'h0000_0013; if_pc = 32'h0;
    step();
    chk("lat_valid", {31'b0, dec_valid}, 32'd1);
    chk("lat_inst", dec_inst, 32'h0000_0013);
    chk("lat_pc", dec_pc, 32'h0);
    if_inst = 32'h0010_0093; if_pc = 32'h4;
    step();
    if_push = 1'b0;
    chk("order_head_hold", dec_inst, 32'h0000_0013);
    dec_ready = 1'b1;
    step();
    chk("order_inst2", dec_inst, 32'h0010_0093);
    chk("order_pc2", dec_pc, 32'h4);
    step();
    dec_ready = 1'b0;
    chk("order_empty", {31'b0, dec_valid}, 32'd0);

    // Full and wrap (pointers start at 2, so tail wraps)
    for (int i = 0; i < 16; i++) push1(32'(i * 4));
    chk("full_set", {31'b0, iq_full}, 32'd1);
    push1(32'hDEAD);
    chk("full_drop_full", {31'b0, iq_full}, 32'd1);
    chk("full_drop_head", dec_pc, 32'h0);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    dec_ready = 1'b0;
    chk("pop4_full", {31'b0, iq_full}, 32'd0);
    chk("pop4_head", dec_pc, 32'h10);
    for (int i = 0; i < 4; i++) push1(32'h40 + 32'(i * 4));
    chk("refill_full", {31'b0, iq_full}, 32'd1);
    dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_pc", dec_pc, 32'h10 + 32'(i * 4));
      chk("wrap_inst", dec_inst, {16'h1300, 16'(32'h10 + 32'(i * 4))});
      step();
    end
    dec_ready = 1'b0;
    chk("wrap_empty", {31'b0, dec_valid}, 32'd0);

    // Simultaneous push/pop at 3 entries
    for (int i = 0; i < 3; i++) push1(32'h200 + 32'(i * 4));
    dec_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("sim_pc", dec_pc, 32'h200 + 32'(k * 4));
      if_push = 1'b1;
      if_pc   = 32'h20C + 32'(k * 4);
      if_inst = {16'h1300, if_pc[15:0]};
      step();
    end
    if_push = 1'b0;
    dec_ready = 1'b0;
    chk("sim_head_after", dec_pc, 32'h250);
    drain(n_pop);
    chk("sim_count", 32'(n_pop), 32'd3);

    // Full queue with push and pop together: pop taken, push dropped
    for (int i = 0; i < 16; i++) push1(32'h300 + 32'(i * 4));
    chk("fpp_full", {31'b0, iq_full}, 32'd1);
    if_push = 1'b1; if_pc = 32'h999; dec_ready = 1'b1;
    step();
    if_push = 1'b0; dec_ready = 1'b0;
    chk("fpp_full_after", {31'b0, iq_full}, 32'd0);
    chk("fpp_head", dec_pc, 32'h304);
    drain(n_pop);
    chk("fpp_count", 32'(n_pop), 32'd15);

    // Flush priority
    for (int i = 0; i < 5; i++) push1(32'h400 + 32'(i * 4));
    rob_clear = 1'b1; if_push = 1'b1; if_pc = 32'h888; dec_ready = 1'b1;
    step();
    rob_clear = 1'b0; if_push = 1'b0; dec_ready = 1'b0;
    chk("flush_valid", {31'b0, dec_valid}, 32'd0);
    chk("flush_full", {31'b0, iq_full}, 32'd0);
    push1(32'h100);
    chk("flush_push_valid", {31'b0, dec_valid}, 32'd1);
    chk("flush_push_pc", dec_pc, 32'h100);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("flush_only_entry", {31'b0, dec_valid}, 32'd0);

    // Stall
    push1(32'h500);
    push1(32'h504);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_push = ~if_push; if_pc = 32'h777; dec_ready = ~dec_ready; rob_clear = ~rob_clear;
      step();
      chk("stall_valid", {31'b0, dec_valid}, 32'd1);
      chk("stall_pc", dec_pc, 32'h500);
    end
    rdy = 1'b1; if_push = 1'b0; dec_ready = 1'b0; rob_clear = 1'b0;
    drain(n_pop);
    chk("stall_count", 32'(n_pop), 32'd2);

    // Asynchronous reset between edges
    push1(32'h600);
    chk("pre_arst_valid", {31'b0, dec_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, dec_valid}, 32'd0);
    chk("arst_full", {31'b0, iq_full}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_arst_valid", {31'b0, dec_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
